// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch handshake controller with PC-tagged instruction FIFO.
// Optional FETCH_TIMEOUT_EN adds a response watchdog driving fetch_err.
module imem_fetch_ctrl #(
    parameter int bits    = 32,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] pc_in,
    input  logic            flush,
    output logic            proc_req,
    output logic            we,
    output logic [bits-1:0] addr,
    input  logic            mem_rdy,
    input  logic            valid,
    input  logic [bits-1:0] Rdata,
    output logic            PC_en,
    output logic            ir_valid,
    output logic [bits-1:0] ir_out,
    output logic [bits-1:0] ir_pc,
    input  logic            ir_ready,
    output logic            fetch_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [bits-1:0] r_addr_q;
    logic [bits-1:0] r_mem_d [DEPTH];
    logic [bits-1:0] r_mem_a [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_load;
    logic            w_block;
    logic            w_tmo;

    assign w_accept    = (r_state == REQ) & mem_rdy;
    assign w_push      = (r_state == WAIT) & valid & ~flush;
    assign w_pop       = ir_valid & ir_ready & ~flush;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    assign proc_req = (r_state == REQ);
    assign we       = 1'b0;
    assign addr     = r_addr_q;
    assign PC_en    = w_accept | flush;
    assign ir_valid = (r_count != '0);
    assign ir_out   = r_mem_d[r_rptr];
    assign ir_pc    = r_mem_a[r_rptr];

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;
    logic          w_waiting;

    assign w_waiting = (r_state == WAIT) | (r_state == DROP);
    assign w_tmo     = w_waiting & ~valid & ~flush
                     & (r_tmo_cnt == TW'(TIMEOUT - 1));
    assign w_block   = r_err;
    assign fetch_err = r_err | w_tmo;

    // Counter restarts whenever WAIT/DROP is (re-)entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= r_err | w_tmo;
            if (w_waiting && (w_state_nxt == r_state))
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            else
                r_tmo_cnt <= '0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign w_tmo     = 1'b0;
    assign w_block   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!flush && !w_block && (r_count < FULL)) begin
                    w_state_nxt = REQ;
                    w_load      = 1'b1;
                end
            end
            REQ: begin
                if (flush)
                    w_state_nxt = w_accept ? DROP : IDLE;
                else if (w_accept)
                    w_state_nxt = WAIT;
            end
            WAIT: begin
                if (valid) begin
                    if (flush) begin
                        w_state_nxt = IDLE;
                    end else if ((w_count_nxt < FULL) && !w_block) begin
                        w_state_nxt = REQ;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (flush) begin
                    w_state_nxt = DROP;
                end else if (w_tmo) begin
                    w_state_nxt = IDLE;
                end
            end
            DROP: begin
                if (valid || w_tmo)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_addr_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load)
                r_addr_q <= pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_d[i] <= '0;
                r_mem_a[i] <= '0;
            end
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem_d[r_wptr] <= Rdata;
                r_mem_a[r_wptr] <= r_addr_q;
                r_wptr          <= r_wptr + AW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed testbench for imem_fetch_ctrl.
// The bench models the fetch PC register: on PC_en it loads jpc or pc+4.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        flush;
    logic        proc_req;
    logic        we;
    logic [31:0] addr;
    logic        mem_rdy;
    logic        valid;
    logic [31:0] Rdata;
    logic        PC_en;
    logic        ir_valid;
    logic [31:0] ir_out;
    logic [31:0] ir_pc;
    logic        ir_ready;
    logic        fetch_err;
    logic [31:0] jpc;

    int tests;
    int fails;

    imem_fetch_ctrl #(.bits(32), .DEPTH(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .flush(flush),
        .proc_req(proc_req), .we(we), .addr(addr), .mem_rdy(mem_rdy),
        .valid(valid), .Rdata(Rdata), .PC_en(PC_en),
        .ir_valid(ir_valid), .ir_out(ir_out), .ir_pc(ir_pc),
        .ir_ready(ir_ready), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        logic en;
        logic f;
        #1;
        en = PC_en;
        f  = flush;
        @(posedge clk);
        #1;
        if (en) pc_in = f ? jpc : pc_in + 32'd4;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; pc_in = '0; flush = 1'b0; mem_rdy = 1'b0;
        valid = 1'b0; Rdata = '0; ir_ready = 1'b0; jpc = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        tests++; if ({proc_req, we, addr, PC_en, ir_valid, ir_out, ir_pc, fetch_err} !== '0) begin fails++; $display("FAIL reset_outs: got req=%0b addr=%h pcen=%0b irv=%0b", proc_req, addr, PC_en, ir_valid); end
        rst = 1'b1; mem_rdy = 1'b1;
        tick();
        tests++; if (proc_req !== 1'b1 || addr !== 32'h0) begin fails++; $display("FAIL reset_first_req: got req=%0b addr=%h want 1 0", proc_req, addr); end
        tick();
        rst = 1'b0; #1;
        tests++; if ({proc_req, we, addr, PC_en, ir_valid, ir_out, ir_pc, fetch_err} !== '0) begin fails++; $display("FAIL reset_mid_wait: got req=%0b addr=%h pcen=%0b irv=%0b", proc_req, addr, PC_en, ir_valid); end
        pc_in = '0; mem_rdy = 1'b0;
        tick(); tick();
        rst = 1'b1; #1;
        tests++; if (proc_req !== 1'b0 || ir_valid !== 1'b0) begin fails++; $display("FAIL reset_idle: got req=%0b irv=%0b want 0 0", proc_req, ir_valid); end
        tick();
        tests++; if (proc_req !== 1'b1 || addr !== 32'h0) begin fails++; $display("FAIL reset_req_after: got req=%0b addr=%h want 1 0", proc_req, addr); end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        mem_rdy = 1'b1; ir_ready = 1'b1;
        tick();
        #1;
        tests++; if (PC_en !== 1'b1 || addr !== 32'h0) begin fails++; $display("FAIL basic_accept: got pcen=%0b addr=%h want 1 0", PC_en, addr); end
        tick();
        valid = 1'b1; Rdata = 32'h00500093; #1;
        tests++; if (PC_en !== 1'b0) begin fails++; $display("FAIL basic_pcen_wait: got %0b want 0", PC_en); end
        tick();
        valid = 1'b0; #1;
        tests++; if (ir_valid !== 1'b1 || ir_out !== 32'h00500093 || ir_pc !== 32'h0) begin fails++; $display("FAIL basic_first: got v=%0b ir=%h pc=%h", ir_valid, ir_out, ir_pc); end
        tests++; if (proc_req !== 1'b1 || addr !== 32'h4 || PC_en !== 1'b1) begin fails++; $display("FAIL basic_second_req: got req=%0b addr=%h pcen=%0b", proc_req, addr, PC_en); end
        tick();
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL basic_popped: got %0b want 0", ir_valid); end
        valid = 1'b1; Rdata = 32'h00100113;
        tick();
        valid = 1'b0; #1;
        tests++; if (ir_valid !== 1'b1 || ir_out !== 32'h00100113 || ir_pc !== 32'h4) begin fails++; $display("FAIL basic_second: got v=%0b ir=%h pc=%h", ir_valid, ir_out, ir_pc); end
    endtask

    task automatic test_backpressure();
        logic acc;
        int   nreq;
        int   npe;
        do_reset();
        mem_rdy = 1'b1; ir_ready = 1'b0;
        nreq = 0; npe = 0;
        repeat (12) begin
            #1;
            acc = proc_req & mem_rdy;
            if (acc) nreq++;
            if (PC_en) npe++;
            tick();
            valid = acc;
            Rdata = (nreq == 1) ? 32'h11111111 : 32'h22222222;
        end
        valid = 1'b0; #1;
        tests++; if (nreq != 2) begin fails++; $display("FAIL bp_req_count: got %0d want 2", nreq); end
        tests++; if (npe != 2) begin fails++; $display("FAIL bp_pcen_count: got %0d want 2", npe); end
        tests++; if (proc_req !== 1'b0 || ir_valid !== 1'b1) begin fails++; $display("FAIL bp_stall: got req=%0b irv=%0b want 0 1", proc_req, ir_valid); end
        ir_ready = 1'b1; #1;
        tests++; if (ir_pc !== 32'h0 || ir_out !== 32'h11111111) begin fails++; $display("FAIL bp_pop0: got pc=%h ir=%h", ir_pc, ir_out); end
        tick();
        tests++; if (ir_valid !== 1'b1 || ir_pc !== 32'h4 || ir_out !== 32'h22222222 || proc_req !== 1'b0) begin fails++; $display("FAIL bp_pop1: got v=%0b pc=%h ir=%h req=%0b", ir_valid, ir_pc, ir_out, proc_req); end
        tick();
        tests++; if (ir_valid !== 1'b0 || proc_req !== 1'b1 || addr !== 32'h8) begin fails++; $display("FAIL bp_resume: got v=%0b req=%0b addr=%h", ir_valid, proc_req, addr); end
    endtask

    task automatic test_flush_wait();
        do_reset();
        mem_rdy = 1'b1; ir_ready = 1'b0;
        tick();
        tick();
        valid = 1'b1; Rdata = 32'h0badf00d;
        tick();
        valid = 1'b0;
        tick();
        #1;
        tests++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0) begin fails++; $display("FAIL fw_prefill: got v=%0b pc=%h want 1 0", ir_valid, ir_pc); end
        flush = 1'b1; jpc = 32'h100; mem_rdy = 1'b0; #1;
        tests++; if (PC_en !== 1'b1) begin fails++; $display("FAIL fw_pcen: got %0b want 1", PC_en); end
        tick();
        flush = 1'b0; #1;
        tests++; if (ir_valid !== 1'b0 || proc_req !== 1'b0 || PC_en !== 1'b0) begin fails++; $display("FAIL fw_cleared: got v=%0b req=%0b pcen=%0b", ir_valid, proc_req, PC_en); end
        valid = 1'b1; Rdata = 32'hdeadbeef;
        tick();
        valid = 1'b0; #1;
        tests++; if (ir_valid !== 1'b0 || proc_req !== 1'b0) begin fails++; $display("FAIL fw_discard: got v=%0b req=%0b want 0 0", ir_valid, proc_req); end
        tick();
        tests++; if (proc_req !== 1'b1 || addr !== 32'h100 || ir_valid !== 1'b0) begin fails++; $display("FAIL fw_new_req: got req=%0b addr=%h v=%0b", proc_req, addr, ir_valid); end
    endtask

    task automatic test_flush_req();
        do_reset();
        mem_rdy = 1'b0; ir_ready = 1'b0;
        tick();
        tick();
        tick();
        #1;
        tests++; if (proc_req !== 1'b1 || addr !== 32'h0 || PC_en !== 1'b0) begin fails++; $display("FAIL fr_stall: got req=%0b addr=%h pcen=%0b", proc_req, addr, PC_en); end
        flush = 1'b1; jpc = 32'h100; #1;
        tests++; if (PC_en !== 1'b1) begin fails++; $display("FAIL fr_pcen: got %0b want 1", PC_en); end
        tick();
        flush = 1'b0; #1;
        tests++; if (proc_req !== 1'b0) begin fails++; $display("FAIL fr_withdrawn: got %0b want 0", proc_req); end
        tick();
        tests++; if (proc_req !== 1'b1 || addr !== 32'h100) begin fails++; $display("FAIL fr_new_req: got req=%0b addr=%h", proc_req, addr); end
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0; valid = 1'b1; Rdata = 32'h00000013;
        tick();
        valid = 1'b0; #1;
        tests++; if (ir_valid !== 1'b1 || ir_pc !== 32'h100 || ir_out !== 32'h00000013) begin fails++; $display("FAIL fr_no_drop: got v=%0b pc=%h ir=%h", ir_valid, ir_pc, ir_out); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        mem_rdy = 1'b1;
        tick();
        tick();
        mem_rdy = 1'b0;
        for (int i = 1; i < 8; i++) begin
            #1;
            tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL to_early c%0d: got %0b want 0", i, fetch_err); end
            tick();
        end
        #1;
        tests++; if (fetch_err !== 1'b1) begin fails++; $display("FAIL to_fire: got %0b want 1", fetch_err); end
        mem_rdy = 1'b1;
        repeat (4) tick();
        tests++; if (fetch_err !== 1'b1 || proc_req !== 1'b0) begin fails++; $display("FAIL to_sticky: got err=%0b req=%0b want 1 0", fetch_err, proc_req); end
        rst = 1'b0; #1;
        tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL to_clear: got %0b want 0", fetch_err); end
    endtask
`endif

    initial begin
        tests = 0; fails = 0;
        clk = 1'b0; rst = 1'b0; pc_in = '0; flush = 1'b0; mem_rdy = 1'b0;
        valid = 1'b0; Rdata = '0; ir_ready = 1'b0; jpc = '0;
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_flush_wait();
        test_flush_req();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction-memory handshake controller between the fetch stage and instruction memory. It issues read requests for the current PC and generates the PC_en advance strobe for the fetch PC register. Returned instructions are buffered with their PC in a small FIFO toward decode. Jumps are handled by flushing the FIFO and discarding any in-flight response.

Parameters:
bits, 32, data/address width
DEPTH, 2, instruction FIFO entries (power of two, >=2)
TIMEOUT, 64, cycles to wait for valid before fetch_err (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
pc_in  in  bits  current PC from fetch PC register
flush  in  1  jump taken (the fetch j select)
proc_req  out  1  memory request
we  out  1  write enable to memory, constant 0
addr  out  bits  request address
mem_rdy  in  1  memory accepts request
valid  in  1  read data valid
Rdata  in  bits  read data
PC_en  out  1  advance/load fetch PC register
ir_valid  out  1  FIFO head valid toward decode
ir_out  out  bits  head instruction
ir_pc  out  bits  PC of head instruction
ir_ready  in  1  decode consumes head
fetch_err  out  1  memory timeout (optional feature)

Behaviour:
- Reset (rst=0, async): state IDLE; FIFO empty; proc_req=0, addr=0, PC_en=0, ir_valid=0, ir_out=0, ir_pc=0, fetch_err=0. we is 0 always.
- FSM states: IDLE, REQ, WAIT, DROP. At most one outstanding request.
- IDLE:
  - Moves to REQ when count<DEPTH and flush=0.
  - On the transition, addr_q<=pc_in.
- REQ:
  - proc_req=1; addr=addr_q, held stable while in REQ.
  - Accept = proc_req & mem_rdy.
  - Accept & !flush -> WAIT.
  - Accept & flush -> DROP.
  - !Accept & flush -> IDLE, request withdrawn.
- WAIT:
  - On valid & !flush: push {Rdata, addr_q}.
  - Next state after the push: REQ with addr_q<=pc_in if space remains after the push, else IDLE.
  - flush with valid in the same cycle: data discarded, FIFO cleared, -> IDLE.
  - flush without valid -> DROP.
- DROP:
  - Waits for valid and discards it.
  - Then -> IDLE.
  - A further flush while in DROP stays in DROP.
- PC_en = (Accept & !flush) | flush. It pulses exactly one cycle per accepted request, so pc_in already holds the next PC in WAIT. On flush it loads jPC.
- Issue gating: the FIFO count plus the outstanding request never exceeds DEPTH. A request is therefore issued only if count<DEPTH when entering REQ, and a push never overflows.
- FIFO:
  - Registered outputs.
  - Pop when ir_valid & ir_ready.
  - Push and pop in the same cycle are both performed; count unchanged.
  - Pointers wrap modulo DEPTH.
  - ir_valid=(count!=0).
  - flush clears count and pointers in the same cycle; ir_valid=0 the next cycle.
- Latency: accept at cycle t, valid at t+k (k>=1), ir_valid=1 at t+k+1. Back-to-back issue gives one instruction per 2 cycles at k=1.
- valid outside WAIT/DROP is ignored.
- mem_rdy held low: stay in REQ indefinitely with addr stable.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on entry to WAIT or DROP and increments each cycle in those states.
  - Reaching TIMEOUT-1 without valid sets fetch_err=1 (sticky until reset) and returns to IDLE; FIFO untouched.
  - While fetch_err=1, no new requests are issued.
- Undefined: no counter; fetch_err tied 0; WAIT/DROP wait forever.

Test Plan:
- Reset: rst=0 mid-WAIT, then release -> all outputs 0, state IDLE, FIFO empty; first request addr=pc_in=0x0 one cycle later.
- Basic fetch:
  - Stimulus: mem_rdy=1; valid one cycle after accept with Rdata=0x00500093; ir_ready=1.
  - Response: PC_en single pulse per accept; ir_out=0x00500093 with ir_pc=0x0, then ir_pc=0x4 next instruction.
- Backpressure: ir_ready=0 with DEPTH=2 -> exactly 2 requests issued, then proc_req stays 0. Raising ir_ready pops 0x0 then 0x4, and issue resumes.
- Flush in WAIT: jump to 0x100 before valid -> PC_en=1 in the flush cycle, the late Rdata is discarded, and the FIFO is cleared. Next addr=0x100; no stale ir_valid.
- Flush in REQ with mem_rdy=0 -> proc_req drops the next cycle; the new request addr=0x100; no DROP entered.
- FETCH_TIMEOUT_EN, TIMEOUT=8: accept, never assert valid -> fetch_err=1 in the 8th WAIT cycle, proc_req stays 0 afterward, and fetch_err clears only on rst=0.
